// File: rtl/calc1_pkg.sv
// rtl/calc1_pkg.sv - shared encodings and port FSM states for the calc1 port scheduler
package calc1_pkg;

  localparam int NUM_PORTS = 4;

  typedef logic [0:3] cmd_t;
  typedef logic [0:1] resp_t;

  localparam cmd_t CMD_NOP = 4'd0;
  localparam cmd_t CMD_ADD = 4'd1;
  localparam cmd_t CMD_SUB = 4'd2;
  localparam cmd_t CMD_SHL = 4'd5;
  localparam cmd_t CMD_SHR = 4'd6;

  localparam resp_t RESP_NONE = 2'd0;
  localparam resp_t RESP_OK   = 2'd1;
  localparam resp_t RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPERAND = 2'd1,
    WAIT    = 2'd2,
    BUSY    = 2'd3
  } port_state_t;

endpackage

// File: rtl/calc1_port_scheduler_if.sv
// rtl/calc1_port_scheduler_if.sv - four requester command ports and their response ports
interface calc1_port_scheduler_if #(parameter int DATA_W = 32);
  import calc1_pkg::*;

  cmd_t              req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in;
  logic [0:DATA_W-1] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
  resp_t             out_resp1, out_resp2, out_resp3, out_resp4;
  logic [0:DATA_W-1] out_data1, out_data2, out_data3, out_data4;

  modport master (
    output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    input  out_resp1, out_resp2, out_resp3, out_resp4,
    input  out_data1, out_data2, out_data3, out_data4
  );

  modport slave (
    input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    output out_resp1, out_resp2, out_resp3, out_resp4,
    output out_data1, out_data2, out_data3, out_data4
  );

endinterface

// File: rtl/calc1_sched_alu.sv
// rtl/calc1_sched_alu.sv - combinational calc1 operation and response code
module calc1_sched_alu
  import calc1_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  cmd_t              cmd,
  input  logic [0:DATA_W-1] op1,
  input  logic [0:DATA_W-1] op2,
  output resp_t             resp,
  output logic [0:DATA_W-1] result
);

  // bit 0 of the widened sum is the carry out
  logic [0:DATA_W] sum;

  always_comb begin
    sum    = {1'b0, op1} + {1'b0, op2};
    resp   = RESP_ERR;
    result = '0;
    case (cmd)
      CMD_ADD: begin
        if (!sum[0]) begin
          resp   = RESP_OK;
          result = sum[1:DATA_W];
        end
      end
      CMD_SUB: begin
        if (op2 <= op1) begin
          resp   = RESP_OK;
          result = op1 - op2;
        end
      end
      CMD_SHL: begin
        resp   = RESP_OK;
        result = op1 << op2[DATA_W-5:DATA_W-1];
      end
      CMD_SHR: begin
        resp   = RESP_OK;
        result = op1 >> op2[DATA_W-5:DATA_W-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/calc1_port_scheduler.sv
// rtl/calc1_port_scheduler.sv - four calc1 ports sharing one ALU through a round-robin arbiter
module calc1_port_scheduler
  import calc1_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ALU_STAGES = 2
) (
  input logic                   c_clk,
  input logic                   reset_n,
  calc1_port_scheduler_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [1:0]        port;
    resp_t             resp;
    logic [0:DATA_W-1] data;
  } stage_t;

  cmd_t              cmd_in  [NUM_PORTS];
  logic [0:DATA_W-1] data_in [NUM_PORTS];

  port_state_t       state_q [NUM_PORTS];
  port_state_t       state_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] cap_cmd, cap_op2, wait_req, resp_hit;

  cmd_t              cmd_q [NUM_PORTS];
  logic [0:DATA_W-1] op1_q [NUM_PORTS];
  logic [0:DATA_W-1] op2_q [NUM_PORTS];

  logic [1:0]        rr_q;
  logic              gnt_valid;
  logic [1:0]        gnt_port;
  logic [1:0]        scan_idx;

  resp_t             alu_resp;
  logic [0:DATA_W-1] alu_data;
  stage_t            alu_stage;
  stage_t            tail;

  resp_t             out_resp_q [NUM_PORTS];
  logic [0:DATA_W-1] out_data_q [NUM_PORTS];

  assign cmd_in[0]  = bus.req1_cmd_in;
  assign cmd_in[1]  = bus.req2_cmd_in;
  assign cmd_in[2]  = bus.req3_cmd_in;
  assign cmd_in[3]  = bus.req4_cmd_in;
  assign data_in[0] = bus.req1_data_in;
  assign data_in[1] = bus.req2_data_in;
  assign data_in[2] = bus.req3_data_in;
  assign data_in[3] = bus.req4_data_in;

  assign bus.out_resp1 = out_resp_q[0];
  assign bus.out_resp2 = out_resp_q[1];
  assign bus.out_resp3 = out_resp_q[2];
  assign bus.out_resp4 = out_resp_q[3];
  assign bus.out_data1 = out_data_q[0];
  assign bus.out_data2 = out_data_q[1];
  assign bus.out_data3 = out_data_q[2];
  assign bus.out_data4 = out_data_q[3];

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      resp_hit[p] = tail.valid && (tail.port == 2'(p));
    end
  end

  always_ff @(posedge c_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!reset_n) begin
        state_q[p] <= IDLE;
      end else begin
        state_q[p] <= state_d[p];
      end
    end
  end

  // BUSY leaves as the response is loaded, so IDLE coincides with the response cycle
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      state_d[p] = state_q[p];
      case (state_q[p])
        IDLE:    if (cmd_in[p] != CMD_NOP) state_d[p] = OPERAND;
        OPERAND: state_d[p] = WAIT;
        WAIT:    if (gnt_valid && (gnt_port == 2'(p))) state_d[p] = BUSY;
        BUSY:    if (resp_hit[p]) state_d[p] = IDLE;
        default: state_d[p] = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      cap_cmd[p]  = (state_q[p] == IDLE) && (cmd_in[p] != CMD_NOP);
      cap_op2[p]  = (state_q[p] == OPERAND);
      wait_req[p] = (state_q[p] == WAIT);
    end
  end

  always_ff @(posedge c_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (cap_cmd[p]) begin
        cmd_q[p] <= cmd_in[p];
        op1_q[p] <= data_in[p];
      end
      if (cap_op2[p]) begin
        op2_q[p] <= data_in[p];
      end
    end
  end

  // first waiting port at or after the pointer wins
  always_comb begin
    gnt_valid = 1'b0;
    gnt_port  = rr_q;
    scan_idx  = rr_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan_idx = rr_q + 2'(i);
      if (!gnt_valid && wait_req[scan_idx]) begin
        gnt_valid = 1'b1;
        gnt_port  = scan_idx;
      end
    end
  end

  always_ff @(posedge c_clk) begin
    if (!reset_n) begin
      rr_q <= 2'd0;
    end else if (gnt_valid) begin
      rr_q <= gnt_port + 2'd1;
    end
  end

  calc1_sched_alu #(.DATA_W(DATA_W)) u_alu (
    .cmd    (cmd_q[gnt_port]),
    .op1    (op1_q[gnt_port]),
    .op2    (op2_q[gnt_port]),
    .resp   (alu_resp),
    .result (alu_data)
  );

  always_comb begin
    alu_stage.valid = gnt_valid;
    alu_stage.port  = gnt_port;
    alu_stage.resp  = alu_resp;
    alu_stage.data  = alu_data;
  end

  // the per-port output registers form the last of the ALU_STAGES stages
  if (ALU_STAGES > 1) begin : g_pipe
    stage_t pipe [ALU_STAGES-1];

    always_ff @(posedge c_clk) begin
      if (!reset_n) begin
        for (int i = 0; i < ALU_STAGES-1; i++) begin
          pipe[i] <= '0;
        end
      end else begin
        pipe[0] <= alu_stage;
        for (int i = 1; i < ALU_STAGES-1; i++) begin
          pipe[i] <= pipe[i-1];
        end
      end
    end

    assign tail = pipe[ALU_STAGES-2];
  end else begin : g_direct
    assign tail = alu_stage;
  end

  always_ff @(posedge c_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!reset_n || !resp_hit[p]) begin
        out_resp_q[p] <= RESP_NONE;
        out_data_q[p] <= '0;
      end else begin
        out_resp_q[p] <= tail.resp;
        out_data_q[p] <= tail.data;
      end
    end
  end

endmodule
